// File: rtl/rng_lfsr16.sv
// rng_lfsr16: free-running 16-bit maximal-length Fibonacci LFSR (x^16+x^14+x^13+x^11+1).
// Optional runtime reseed ports are enabled with `define RNG_RESEED_EN.
module rng_lfsr16 #(
  parameter logic [15:0] S = 16'h0001
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] rng_o
`ifdef RNG_RESEED_EN
  ,
  input  logic [15:0] seed_i,
  input  logic        seed_load_i
`endif
);
  localparam logic [15:0] LOCKUP_FIX = 16'hACE1;
  localparam logic [15:0] SEED = (S != 16'h0000) ? S : LOCKUP_FIX;
  logic [15:0] s, step, nxt;
  logic        fb;
  always_comb begin
    fb   = s[15] ^ s[13] ^ s[12] ^ s[10];
    // All-zero is the lockup state; escape it rather than stay stuck.
    step = (s == 16'h0000) ? LOCKUP_FIX : {s[14:0], fb};
`ifdef RNG_RESEED_EN
    nxt  = seed_load_i ? ((seed_i != 16'h0000) ? seed_i : LOCKUP_FIX) : step;
`else
    nxt  = step;
`endif
  end
  always_ff @(posedge clk)
    s <= reset ? SEED : nxt;
  assign rng_o = s;
endmodule

// File: tb/tb_rng_lfsr16.sv
// tb_rng_lfsr16: directed checks of seeded reset, stepping, mid-run reset, full period and bit balance.
module tb_rng_lfsr16;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] rng, rng0;
  int          passed = 0;
  int          total = 0;
`ifdef RNG_RESEED_EN
  logic [15:0] seed_i = 16'h0000;
  logic        seed_load_i = 1'b0;
  logic [15:0] seed0_unused = 16'h0000;
  logic        load0_unused = 1'b0;
`endif

  always #5 clk = ~clk;

  rng_lfsr16 #(.S(16'h1234)) dut (
    .clk(clk), .reset(reset), .rng_o(rng)
`ifdef RNG_RESEED_EN
    , .seed_i(seed_i), .seed_load_i(seed_load_i)
`endif
  );

  rng_lfsr16 #(.S(16'h0000)) dut0 (
    .clk(clk), .reset(reset), .rng_o(rng0)
`ifdef RNG_RESEED_EN
    , .seed_i(seed0_unused), .seed_load_i(load0_unused)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          thr;
    int          ones;
    logic        early;
    logic        zero;
    tick();
    check("reset_seed", {16'h0, rng}, 32'h1234);
    check("reset_seed_zero_param", {16'h0, rng0}, 32'hACE1);
    tick();
    check("reset_held", {16'h0, rng}, 32'h1234);
    reset = 1'b0;
    tick();
    check("step1", {16'h0, rng}, 32'h2469);
    check("step1_zero_param", {16'h0, rng0}, 32'h59C3);
    tick();
    check("step2", {16'h0, rng}, 32'h48D2);
    tick();
    check("step3", {16'h0, rng}, 32'h91A4);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrun_reset_hold", {16'h0, rng}, 32'h1234);
    end
    reset = 1'b0;
    tick();
    check("after_reset_step1", {16'h0, rng}, 32'h2469);
    tick();
    check("after_reset_step2", {16'h0, rng}, 32'h48D2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("period_start", {16'h0, rng}, 32'h1234);
    thr = 0;
    ones = 0;
    early = 1'b0;
    zero = 1'b0;
    for (int k = 1; k <= 65535; k++) begin
      thr += int'(rng[14] | rng[13]);
      ones += int'(rng[0]);
      tick();
      if (rng == 16'h0000) zero = 1'b1;
      if (k < 65535 && rng == 16'h1234) early = 1'b1;
    end
    check("period_return", {16'h0, rng}, 32'h1234);
    check("no_early_repeat", {31'h0, early}, 32'h0);
    check("never_zero", {31'h0, zero}, 32'h0);
    check("throttle_count", thr, 32'd49152);
    check("bit0_ones", ones, 32'd32768);
`ifdef RNG_RESEED_EN
    seed_i = 16'h0001;
    seed_load_i = 1'b1;
    tick();
    check("reseed_load", {16'h0, rng}, 32'h0001);
    seed_load_i = 1'b0;
    tick();
    check("reseed_step1", {16'h0, rng}, 32'h0002);
    tick();
    check("reseed_step2", {16'h0, rng}, 32'h0004);
    seed_i = 16'h0000;
    seed_load_i = 1'b1;
    tick();
    check("reseed_zero", {16'h0, rng}, 32'hACE1);
    seed_i = 16'h0005;
    reset = 1'b1;
    tick();
    check("reset_beats_load", {16'h0, rng}, 32'h1234);
    reset = 1'b0;
    seed_load_i = 1'b0;
    tick();
    check("post_priority_step", {16'h0, rng}, 32'h2469);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
